store_narrow: RTL and testbench
===============================

# store_narrow

Store-side narrowing unit for the data-memory path: the write-direction counterpart of the load/immediate extender. It accepts a 32-bit store request with a byte/halfword/word size and checks alignment. It truncates the data to the requested width and serializes it little-endian onto an 8-bit data-memory write port, one byte per acknowledged cycle. It sits between the CPU's store datapath and a byte-wide data memory.

## Interface
- ADDR_W, 32, width of request and memory addresses
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  32  store data; only the low 8/16/32 bits are used per size
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (illegal)
- mem_we  out  1  byte write request to memory
- mem_addr  out  ADDR_W  byte address of the current write
- mem_wdata  out  8  byte being written
- mem_ack  in  1  memory accepts the byte when mem_we && mem_ack
- done  out  1  one-cycle pulse: store completed
- misalign  out  1  one-cycle pulse: request rejected (misaligned or size 11)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, DONE, ERR.
- IDLE: req_ready=1. A request is accepted on the clk edge where req_valid && req_ready.
  - Illegal request: req_size=11, or halfword with addr[0]=1, or word with addr[1:0]!=00. The unit goes to ERR. No memory write is issued.
  - Legal request: the unit latches addr, data and last = bytes-1 (0, 1 or 3), sets idx=0, and goes to WRITE.
- WRITE:
  - mem_we=1, mem_addr=base+idx, mem_wdata=data[8*idx+7:8*idx].
  - On mem_ack with idx==last, go to DONE. Otherwise idx increments and the unit stays in WRITE.
  - Without mem_ack, all outputs hold unchanged.
- DONE: done=1 for one cycle, then IDLE.
- ERR: misalign=1 for one cycle, then IDLE.
- Truncation rule: bits above the access width are ignored, never checked.
- Address arithmetic is modulo 2^ADDR_W. Aligned accesses never cross a word boundary, so there is no wrap inside an access.
- req_data, req_addr and req_size are sampled only at acceptance. Later changes have no effect.
- mem_we, done and misalign are mutually exclusive.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - state=IDLE, req_ready=1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - done=0, misalign=0, busy=0
- Reset mid-operation aborts immediately:
  - mem_we drops with rst, with no clock needed.
  - No done pulse; the remaining bytes are not written.
- Latency, acceptance edge = cycle 0, mem_ack held high:
  - byte: write in cycle 1, done in cycle 2
  - half: writes in cycles 1-2, done in cycle 3
  - word: writes in cycles 1-4, done in cycle 5
  - The next request can be accepted at the end of the DONE cycle's successor, i.e. IDLE in cycle 6 for a word.
- Each cycle mem_ack is low during WRITE adds exactly one cycle.
- Error path: misalign high in cycle 1, req_ready high again in cycle 2.
- req_valid arriving while busy is ignored (req_ready=0). The requester must hold it.
- mem_ack outside WRITE is ignored.

## Test plan
- Word store, req_addr=0x100, req_data=0xA1B2C3D4, mem_ack=1 -> writes (0x100,D4), (0x101,C3), (0x102,B2), (0x103,A1) in cycles 1-4; done in cycle 5.
- Byte store, addr=0x203, data=0xFFFFFF5A -> single write (0x203,5A); done in cycle 2; upper bits never appear.
- Halfword, addr=0x10, data=0x00001234, mem_ack low for 2 cycles on the first byte -> (0x10,34) held for 3 cycles, then (0x11,12); done in cycle 5.
- Misaligned word at addr=0x102, then halfword at 0x1, then size=11 at 0x0 -> each gives a misalign pulse in cycle 1, mem_we stays 0, req_ready returns in cycle 2.
- rst asserted asynchronously after the second byte of a word store -> mem_we=0 immediately, no done; after release, a byte store to 0x0 completes normally.
- req_valid held during busy with changing req_data -> only the first request is written; the second is accepted in IDLE after done.

Source files
------------

// File: rtl/store_narrow.sv
// ---------------------------------------------------------------------------
// store_narrow
// Store-side narrowing unit for the data-memory path. A 32-bit store request
// (byte / halfword / word) is checked for alignment, truncated to its access
// width and written little-endian onto a byte-wide memory port, one byte per
// acknowledged cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_req_valid  store request present
//   o_req_ready  unit can accept a request (high only while idle)
//   i_req_addr   byte address of the store
//   i_req_data   store data; only the low 8/16/32 bits are used
//   i_req_size   00 byte, 01 halfword, 10 word, 11 reserved (rejected)
//   o_mem_we     byte write request to memory
//   o_mem_addr   byte address of the current write
//   o_mem_wdata  byte being written
//   i_mem_ack    memory accepts the byte when o_mem_we && i_mem_ack
//   o_done       one-cycle pulse: store completed
//   o_misalign   one-cycle pulse: request rejected
//   o_busy       high whenever the unit is not idle
// ---------------------------------------------------------------------------
module store_narrow #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_data,
   input  logic [1:0]        i_req_size,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   input  logic              i_mem_ack,
   output logic              o_done,
   output logic              o_misalign,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_baseAddr;
   logic [31:0]         r_data;
   logic [1:0]          r_lastIdx;
   logic [1:0]          r_idx;

   logic                r_reqReady;
   logic                r_memWe;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [7:0]          r_memWdata;
   logic                r_done;
   logic                r_misalign;
   logic                r_busy;

   logic                w_accept;
   logic                w_illegal;
   logic [1:0]          w_lastReq;
   logic [1:0]          w_idxNext;
   logic [ADDR_W-1:0]   w_addrNext;
   logic [7:0]          w_byteNext;

   // Picks byte lane idx out of a 32-bit word, little-endian.
   function automatic logic [7:0] selectByte(input logic [31:0] data,
                                             input logic [1:0]  idx);
      logic [7:0] sel;
      case (idx)
         2'd0:    sel = data[7:0];
         2'd1:    sel = data[15:8];
         2'd2:    sel = data[23:16];
         default: sel = data[31:24];
      endcase
      return sel;
   endfunction

   // Request classification. Only the address bits below the access width
   // matter for alignment; data bits above the width are never inspected.
   // The reserved size code is treated as illegal regardless of address.
   always_comb begin
      w_accept  = i_req_valid && r_reqReady;
      w_illegal = 1'b0;
      w_lastReq = 2'd0;
      case (i_req_size)
         2'b00: begin
            w_lastReq = 2'd0;
         end
         2'b01: begin
            w_lastReq = 2'd1;
            w_illegal = i_req_addr[0];
         end
         2'b10: begin
            w_lastReq = 2'd3;
            w_illegal = (i_req_addr[1:0] != 2'b00);
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   // Address and data for the byte following the current one. Aligned
   // accesses never cross a word, so a plain modulo-2^ADDR_W add suffices.
   always_comb begin
      w_idxNext  = r_idx + 2'd1;
      w_addrNext = r_baseAddr + {{(ADDR_W-2){1'b0}}, w_idxNext};
      w_byteNext = selectByte(r_data, w_idxNext);
   end

   // Main controller. All outputs are registered and updated together with
   // the state so that o_mem_we, o_done and o_misalign can never overlap.
   // Reset clears everything at once, which also aborts an in-flight store
   // without a done pulse. In WRITE without an ack nothing changes, so the
   // memory sees a stable address and byte until it accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baseAddr <= '0;
         r_data     <= '0;
         r_lastIdx  <= 2'd0;
         r_idx      <= 2'd0;
         r_reqReady <= 1'b1;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_reqReady <= 1'b0;
                  r_busy     <= 1'b1;
                  if (w_illegal) begin
                     r_state    <= ERR;
                     r_misalign <= 1'b1;
                  end else begin
                     r_state    <= WRITE;
                     r_baseAddr <= i_req_addr;
                     r_data     <= i_req_data;
                     r_lastIdx  <= w_lastReq;
                     r_idx      <= 2'd0;
                     r_memWe    <= 1'b1;
                     r_memAddr  <= i_req_addr;
                     r_memWdata <= i_req_data[7:0];
                  end
               end
            end

            WRITE: begin
               if (i_mem_ack) begin
                  if (r_idx == r_lastIdx) begin
                     r_state <= DONE;
                     r_memWe <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx      <= w_idxNext;
                     r_memAddr  <= w_addrNext;
                     r_memWdata <= w_byteNext;
                  end
               end
            end

            DONE: begin
               r_state    <= IDLE;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_reqReady <= 1'b1;
            end

            ERR: begin
               r_state    <= IDLE;
               r_misalign <= 1'b0;
               r_busy     <= 1'b0;
               r_reqReady <= 1'b1;
            end

            default: begin
               r_state    <= IDLE;
               r_memWe    <= 1'b0;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
               r_busy     <= 1'b0;
               r_reqReady <= 1'b1;
            end
         endcase
      end
   end

   assign o_req_ready = r_reqReady;
   assign o_mem_we    = r_memWe;
   assign o_mem_addr  = r_memAddr;
   assign o_mem_wdata = r_memWdata;
   assign o_done      = r_done;
   assign o_misalign  = r_misalign;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_store_narrow.sv
// ---------------------------------------------------------------------------
// tb_store_narrow
// Self-checking bench for store_narrow. Expected memory writes are pushed to
// a scoreboard queue when a request is driven and compared by a monitor as
// the unit presents them; completion timing is checked per request.
// ---------------------------------------------------------------------------
module tb_store_narrow;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req_valid;
   logic              o_req_ready;
   logic [ADDR_W-1:0] i_req_addr;
   logic [31:0]       i_req_data;
   logic [1:0]        i_req_size;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [7:0]        o_mem_wdata;
   logic              i_mem_ack;
   logic              o_done;
   logic              o_misalign;
   logic              o_busy;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      int          stall;
      bit          expMisalign;
      int          expEnd;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  expQ[$];
   vec_t vecs[12];
   int   checkCount = 0;
   int   passCount  = 0;
   int   doneCount  = 0;
   int   writeCount = 0;

   store_narrow #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_addr  (i_req_addr),
      .i_req_data  (i_req_data),
      .i_req_size  (i_req_size),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ack   (i_mem_ack),
      .o_done      (o_done),
      .o_misalign  (o_misalign),
      .o_busy      (o_busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Runaway guard so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Scoreboard monitor: every presented byte must match the head of the
   // expected queue; it is retired only on the cycle the memory acks it.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_done) doneCount++;
         if (o_mem_we) begin
            checkOutput("write expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
               checkOutput("write addr", 64'(o_mem_addr), 64'(expQ[0].addr));
               checkOutput("write data", 64'(o_mem_wdata), 64'(expQ[0].data));
               if (i_mem_ack) begin
                  void'(expQ.pop_front());
                  writeCount++;
               end
            end
         end
         if (o_mem_we || o_done || o_misalign)
            checkOutput("exclusive outputs",
                        64'(o_mem_we) + 64'(o_done) + 64'(o_misalign), 64'd1);
      end
   end

   function automatic int sizeBytes(input logic [1:0] size);
      if (size == 2'b00) return 1;
      if (size == 2'b01) return 2;
      return 4;
   endfunction

   function automatic void pushWrites(input logic [31:0] addr,
                                      input logic [31:0] data,
                                      input logic [1:0]  size);
      wr_t w;
      for (int i = 0; i < sizeBytes(size); i++) begin
         w.addr = addr + 32'(i);
         w.data = 8'(data >> (8 * i));
         expQ.push_back(w);
      end
   endfunction

   // Drives one request from a negedge, withholds the ack for the first
   // v.stall write cycles, and checks the end-pulse cycle and recovery.
   task automatic applyStimulus(input vec_t v);
      int  waitCyc   = 0;
      int  stallLeft = v.stall;
      int  endCyc    = -1;
      bit  sawWe     = 1'b0;
      while (!o_req_ready && waitCyc < 50) begin
         @(negedge clk);
         waitCyc++;
      end
      checkOutput("ready before request", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b1;
      i_req_addr  = v.addr;
      i_req_data  = v.data;
      i_req_size  = v.size;
      i_mem_ack   = (stallLeft == 0);
      if (!v.expMisalign) pushWrites(v.addr, v.data, v.size);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_req_addr  = $urandom;
      i_req_data  = $urandom;
      i_req_size  = 2'($urandom);
      for (int cyc = 1; cyc <= 40 && endCyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checkOutput("busy in cycle 1", 64'(o_busy), 64'd1);
            checkOutput("ready low in cycle 1", 64'(o_req_ready), 64'd0);
         end
         if (o_mem_we) begin
            sawWe = 1'b1;
            if (stallLeft > 0) stallLeft--;
         end
         if (o_done || o_misalign) begin
            endCyc = cyc;
            checkOutput("misalign vs done", 64'(o_misalign), 64'(v.expMisalign));
         end
         @(posedge clk); #1;
         i_mem_ack = (stallLeft == 0);
      end
      checkOutput("end pulse cycle", 64'(endCyc), 64'(v.expEnd));
      @(negedge clk);
      checkOutput("ready after end", 64'(o_req_ready), 64'd1);
      checkOutput("idle after end", 64'(o_busy), 64'd0);
      if (v.expMisalign) checkOutput("no write on reject", 64'(sawWe), 64'd0);
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      i_mem_ack = 1'b1;
   endtask

   initial begin
      int d0;
      int w0;
      int firstDone;
      int secondDone;
      vec_t v;

      // Vector table: address, data, size, stall cycles, reject, end cycle.
      vecs[0]  = '{32'h0000_0100, 32'hA1B2_C3D4, 2'b10, 0, 1'b0, 5};
      vecs[1]  = '{32'h0000_0203, 32'hFFFF_FF5A, 2'b00, 0, 1'b0, 2};
      vecs[2]  = '{32'h0000_0010, 32'h0000_1234, 2'b01, 2, 1'b0, 5};
      vecs[3]  = '{32'h0000_0102, 32'h1111_1111, 2'b10, 0, 1'b1, 1};
      vecs[4]  = '{32'h0000_0001, 32'h2222_2222, 2'b01, 0, 1'b1, 1};
      vecs[5]  = '{32'h0000_0000, 32'h3333_3333, 2'b11, 0, 1'b1, 1};
      vecs[6]  = '{32'h0000_0012, 32'hDEAD_BEEF, 2'b01, 0, 1'b0, 3};
      vecs[7]  = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b10, 1, 1'b0, 6};
      vecs[8]  = '{32'hFFFF_FFFF, 32'h1234_5601, 2'b00, 0, 1'b0, 2};
      vecs[9]  = '{32'h0000_0003, 32'h4444_4444, 2'b01, 0, 1'b1, 1};
      vecs[10] = '{32'h0000_0001, 32'h5555_5555, 2'b10, 0, 1'b1, 1};
      vecs[11] = '{32'h0000_0008, 32'h89AB_CDEF, 2'b10, 3, 1'b0, 8};

      rst         = 1'b1;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      i_req_data  = '0;
      i_req_size  = 2'b00;
      i_mem_ack   = 1'b1;

      #12;
      checkOutput("reset req_ready", 64'(o_req_ready), 64'd1);
      checkOutput("reset mem_we", 64'(o_mem_we), 64'd0);
      checkOutput("reset mem_addr", 64'(o_mem_addr), 64'd0);
      checkOutput("reset mem_wdata", 64'(o_mem_wdata), 64'd0);
      checkOutput("reset done", 64'(o_done), 64'd0);
      checkOutput("reset misalign", 64'(o_misalign), 64'd0);
      checkOutput("reset busy", 64'(o_busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

      // Asynchronous reset in the middle of a word store, after two bytes.
      @(negedge clk);
      d0 = doneCount;
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_0300;
      i_req_data  = 32'h1122_3344;
      i_req_size  = 2'b10;
      i_mem_ack   = 1'b1;
      pushWrites(32'h0000_0300, 32'h1122_3344, 2'b10);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("abort mem_we", 64'(o_mem_we), 64'd0);
      checkOutput("abort busy", 64'(o_busy), 64'd0);
      checkOutput("abort req_ready", 64'(o_req_ready), 64'd1);
      checkOutput("abort mem_addr", 64'(o_mem_addr), 64'd0);
      checkOutput("bytes left after abort", 64'(expQ.size()), 64'd2);
      expQ.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("no done after abort", 64'(doneCount), 64'(d0));
      @(negedge clk);
      v = '{32'h0000_0000, 32'h0000_00C7, 2'b00, 0, 1'b0, 2};
      applyStimulus(v);

      // Request held valid while busy with changing payload: the first
      // payload is written, the second is taken only once idle again.
      @(negedge clk);
      d0 = doneCount;
      w0 = writeCount;
      firstDone  = -1;
      secondDone = -1;
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_0040;
      i_req_data  = 32'h0000_0077;
      i_req_size  = 2'b00;
      i_mem_ack   = 1'b1;
      pushWrites(32'h0000_0040, 32'h0000_0077, 2'b00);
      pushWrites(32'h0000_0041, 32'h0000_0088, 2'b00);
      @(posedge clk); #1;
      i_req_addr = 32'h0000_0041;
      i_req_data = 32'h0000_0088;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (o_done) begin
            if (firstDone < 0) firstDone = cyc;
            else if (secondDone < 0) secondDone = cyc;
         end
         if (cyc == 2) checkOutput("ready low in DONE", 64'(o_req_ready), 64'd0);
         if (cyc == 3) checkOutput("ready after first", 64'(o_req_ready), 64'd1);
         @(posedge clk); #1;
         if (cyc == 3) i_req_valid = 1'b0;
      end
      checkOutput("first done cycle", 64'(firstDone), 64'd2);
      checkOutput("second done cycle", 64'(secondDone), 64'd5);
      checkOutput("held request writes", 64'(writeCount - w0), 64'd2);
      checkOutput("held request dones", 64'(doneCount - d0), 64'd2);
      checkOutput("held scoreboard drained", 64'(expQ.size()), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
